// File: rtl/tcam_rule_loader.sv
// Serialises one rule load (value, mask, action) or a default-action load into the
// dataplane tables, first quiescing lookups and aborting if the dataplane never drains.
module tcam_rule_loader #(
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_is_default,
  input  logic [3:0]   req_idx,
  input  logic [127:0] req_value,
  input  logic [127:0] req_mask,
  input  logic [63:0]  req_action,
  output logic         resp_valid,
  output logic         resp_err,
  input  logic         dp_idle,
  output logic         lookup_hold,
  output logic         cfg_tcam_wr_en,
  output logic         cfg_tcam_wr_is_mask,
  output logic [3:0]   cfg_tcam_wr_addr,
  output logic [127:0] cfg_tcam_wr_data,
  output logic         cfg_action_wr_en,
  output logic [3:0]   cfg_action_wr_addr,
  output logic [63:0]  cfg_action_wr_data,
  output logic         cfg_action_wr_default,
  output logic [63:0]  cfg_action_default_data,
  output logic [15:0]  rule_loaded
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_IDLE  = 3'd1;
  localparam logic [2:0] WR_VALUE   = 3'd2;
  localparam logic [2:0] WR_MASK    = 3'd3;
  localparam logic [2:0] WR_ACTION  = 3'd4;
  localparam logic [2:0] WR_DEFAULT = 3'd5;
  localparam logic [2:0] RESP       = 3'd6;

  localparam logic [15:0] CNT_LAST = 16'(QUIESCE_TIMEOUT - 1);

  logic [2:0]   state_reg, state_next;
  logic [15:0]  cnt_reg, cnt_next;
  logic         err_reg, err_next;
  logic         is_default_reg;
  logic [3:0]   idx_reg;
  logic [127:0] value_reg;
  logic [127:0] mask_reg;
  logic [63:0]  action_reg;
  logic         accept;

  assign accept = req_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = WAIT_IDLE;
          cnt_next   = 16'd0;
          err_next   = 1'b0;
        end
      end
      WAIT_IDLE: begin
        // A drained dataplane on the final counted cycle still wins over the abort.
        if (dp_idle) begin
          state_next = is_default_reg ? WR_DEFAULT : WR_VALUE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      WR_VALUE:   state_next = WR_MASK;
      WR_MASK:    state_next = WR_ACTION;
      WR_ACTION:  state_next = RESP;
      WR_DEFAULT: state_next = RESP;
      RESP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_default_reg <= 1'b0;
      idx_reg        <= 4'd0;
      value_reg      <= 128'd0;
      mask_reg       <= 128'd0;
      action_reg     <= 64'd0;
    end else if (accept) begin
      is_default_reg <= req_is_default;
      idx_reg        <= req_idx;
      value_reg      <= req_value;
      mask_reg       <= req_mask;
      action_reg     <= req_action;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_loaded
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rule_loaded[gi] <= 1'b0;
        end else if ((state_reg == WR_ACTION) && (idx_reg == 4'(gi))) begin
          rule_loaded[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign req_ready               = (state_reg == IDLE);
  assign resp_valid              = (state_reg == RESP);
  assign resp_err                = (state_reg == RESP) && err_reg;
  assign lookup_hold             = (state_reg != IDLE) && (state_reg != RESP);
  assign cfg_tcam_wr_en          = (state_reg == WR_VALUE) || (state_reg == WR_MASK);
  assign cfg_tcam_wr_is_mask     = (state_reg == WR_MASK);
  assign cfg_tcam_wr_addr        = idx_reg;
  assign cfg_tcam_wr_data        = (state_reg == WR_MASK) ? mask_reg : value_reg;
  assign cfg_action_wr_en        = (state_reg == WR_ACTION);
  assign cfg_action_wr_addr      = idx_reg;
  assign cfg_action_wr_data      = action_reg;
  assign cfg_action_wr_default   = (state_reg == WR_DEFAULT);
  assign cfg_action_default_data = action_reg;

endmodule
